// File: rtl/pc_unit_ext_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM encodings and
// default vector/step constants.
package pc_unit_ext_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        TRAP = 2'd3
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0004;
    localparam int          DEF_STEP         = 4;

    function automatic logic target_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a branch redirect that arrives while instruction memory
// is not ready; the newest target overwrites any older one.
module pc_redirect_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] addr,
    input  logic             clear,
    output logic             pend_valid,
    output logic [WIDTH-1:0] pend_addr
);

    // Clear wins over capture: a trap or a consumed redirect empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_addr  <= addr;
        end
    end

endmodule

// File: rtl/pc_unit_ext.sv
// Fetch-stage program counter with stall, imem ready handshake, buffered
// redirect, exception vectoring and misaligned-target trapping.
module pc_unit_ext
    import pc_unit_ext_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               STEP         = DEF_STEP,
    parameter bit               ALIGN_CHECK  = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Stall,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] Result,
    input  logic             Exception,
    input  logic             IMem_Ready,
    output logic [WIDTH-1:0] current_PC,
    output logic [WIDTH-1:0] PC_Plus_4,
    output logic [WIDTH-1:0] PC_Plus_8,
    output logic             Fetch_Valid,
    output logic [WIDTH-1:0] Saved_PC,
    output logic             Misaligned
);

    pc_state_t        state;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_addr;
    logic             mis_target;
    logic             active;
    logic             buf_capture;
    logic             buf_clear;

    assign PC_Plus_4 = current_PC + WIDTH'(STEP);
    assign PC_Plus_8 = current_PC + WIDTH'(2 * STEP);

    assign mis_target = ALIGN_CHECK && PCSrc && target_misaligned(Result[1:0]);
    assign active     = (state == RUN) || (state == WAIT);

    // A redirect is parked only when it neither traps nor can be taken now.
    assign buf_capture = active && PCSrc && !Exception && !mis_target && !IMem_Ready;
    assign buf_clear   = (state == WAIT) && (Exception || mis_target || IMem_Ready);

    assign Fetch_Valid = (state == RUN) && IMem_Ready && !Stall && !PCSrc && !Exception;

    pc_redirect_buf #(.WIDTH(WIDTH)) u_redirect_buf (
        .clk        (CLK),
        .rst_n      (Reset_n),
        .capture    (buf_capture),
        .addr       (Result),
        .clear      (buf_clear),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= BOOT;
            current_PC <= RESET_VECTOR;
            Saved_PC   <= '0;
            Misaligned <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, WAIT: begin
                    if (Exception) begin
                        Saved_PC   <= current_PC;
                        current_PC <= EXC_VECTOR;
                        state      <= TRAP;
                    end else if (mis_target) begin
                        Saved_PC   <= current_PC;
                        Misaligned <= 1'b1;
                        current_PC <= EXC_VECTOR;
                        state      <= TRAP;
                    end else if (!IMem_Ready) begin
                        state <= WAIT;
                    end else begin
                        // Ready: a redirect (live or parked) beats Stall; Stall
                        // only blocks the sequential increment.
                        state <= RUN;
                        if (PCSrc)
                            current_PC <= Result;
                        else if (state == WAIT && pend_valid)
                            current_PC <= pend_addr;
                        else if (!Stall)
                            current_PC <= PC_Plus_4;
                    end
                end
                TRAP: begin
                    Misaligned <= 1'b0;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit_ext.sv
// Scoreboard bench for pc_unit_ext: expected PCs are queued as stimulus is
// driven and compared one edge later; side outputs are checked inline.
module tb_pc_unit_ext;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Stall, PCSrc, Exception, IMem_Ready;
    logic [31:0] Result;
    logic [31:0] current_PC, PC_Plus_4, PC_Plus_8, Saved_PC;
    logic        Fetch_Valid, Misaligned;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    pc_unit_ext dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .Stall       (Stall),
        .PCSrc       (PCSrc),
        .Result      (Result),
        .Exception   (Exception),
        .IMem_Ready  (IMem_Ready),
        .current_PC  (current_PC),
        .PC_Plus_4   (PC_Plus_4),
        .PC_Plus_8   (PC_Plus_8),
        .Fetch_Valid (Fetch_Valid),
        .Saved_PC    (Saved_PC),
        .Misaligned  (Misaligned)
    );

    always #5 CLK = ~CLK;

    // Scoreboard consumer: one expected PC per edge that had stimulus queued.
    always @(posedge CLK) begin
        logic [31:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (current_PC !== e) begin
                n_err++;
                $display("FAIL pc_seq at %0t: got %h want %h", $time, current_PC, e);
            end
        end
    end

    task automatic drive(input logic s, input logic p, input logic [31:0] r,
                         input logic e, input logic rdy);
        @(negedge CLK);
        Stall = s; PCSrc = p; Result = r; Exception = e; IMem_Ready = rdy;
    endtask

    task automatic tick(input logic [31:0] exp_pc);
        exp_q.push_back(exp_pc);
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Stall = 0; PCSrc = 0; Result = 0; Exception = 0; IMem_Ready = 1;
        #1;
        n_vec++;
        if (current_PC !== 32'h0 || Saved_PC !== 32'h0 || Misaligned !== 1'b0 || Fetch_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: pc=%h saved=%h mis=%b fv=%b want 0/0/0/0",
                     current_PC, Saved_PC, Misaligned, Fetch_Valid);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        #1;
        n_vec++;
        if (Fetch_Valid !== 1'b0) begin
            n_err++; $display("FAIL boot_fv: got %b want 0", Fetch_Valid);
        end
        tick(32'h0);
        n_vec++;
        if (Fetch_Valid !== 1'b1) begin
            n_err++; $display("FAIL run_fv: got %b want 1", Fetch_Valid);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 1);
            tick(32'(i * 4));
        end
    endtask

    task automatic test_redirect;
        drive(0, 1, 32'h100, 0, 1);
        #1;
        n_vec++;
        if (Fetch_Valid !== 1'b0) begin
            n_err++; $display("FAIL redirect_fv: got %b want 0", Fetch_Valid);
        end
        tick(32'h100);
        drive(0, 0, 0, 0, 1);
        #1;
        n_vec++;
        if (PC_Plus_8 !== 32'h108 || PC_Plus_4 !== 32'h104) begin
            n_err++; $display("FAIL plus8: got %h/%h want 108/104", PC_Plus_8, PC_Plus_4);
        end
        tick(32'h104);
        drive(0, 1, 32'h20, 0, 1); tick(32'h20);
    endtask

    task automatic test_wait;
        drive(0, 0, 0, 0, 0);         tick(32'h20);
        drive(0, 1, 32'h200, 0, 0);   tick(32'h20);
        drive(0, 1, 32'h300, 0, 0);   tick(32'h20);
        drive(0, 0, 0, 0, 1);
        #1;
        n_vec++;
        if (Fetch_Valid !== 1'b0) begin
            n_err++; $display("FAIL wait_fv: got %b want 0", Fetch_Valid);
        end
        tick(32'h300);
        drive(0, 0, 0, 0, 1);         tick(32'h304);
    endtask

    task automatic test_misalign;
        drive(0, 1, 32'h40, 0, 1);    tick(32'h40);
        drive(0, 1, 32'h102, 0, 1);   tick(32'h4);
        n_vec++;
        if (Misaligned !== 1'b1 || Saved_PC !== 32'h40 || Fetch_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_trap: mis=%b saved=%h fv=%b want 1/40/0", Misaligned, Saved_PC, Fetch_Valid);
        end
        // Exception and redirect during TRAP must be ignored.
        drive(0, 1, 32'h900, 1, 1);   tick(32'h4);
        n_vec++;
        if (Misaligned !== 1'b0 || Saved_PC !== 32'h40) begin
            n_err++; $display("FAIL trap_exit: mis=%b saved=%h want 0/40", Misaligned, Saved_PC);
        end
        drive(0, 0, 0, 0, 1);         tick(32'h8);
    endtask

    task automatic test_exception;
        drive(0, 1, 32'h80, 0, 1);    tick(32'h80);
        drive(0, 1, 32'h500, 1, 1);   tick(32'h4);
        n_vec++;
        if (Saved_PC !== 32'h80 || Misaligned !== 1'b0) begin
            n_err++; $display("FAIL exc_trap: saved=%h mis=%b want 80/0", Saved_PC, Misaligned);
        end
        drive(0, 0, 0, 0, 1);         tick(32'h4);
        drive(0, 0, 0, 0, 1);         tick(32'h8);
    endtask

    task automatic test_back_to_back;
        drive(0, 0, 0, 0, 0);         tick(32'h8);
        drive(1, 0, 0, 0, 1);         tick(32'h8);
        drive(0, 0, 0, 0, 1);         tick(32'hC);
        drive(0, 1, 32'h600, 0, 0);   tick(32'hC);
        drive(1, 0, 0, 0, 1);         tick(32'h600);
        drive(0, 0, 0, 0, 1);         tick(32'h604);
        drive(0, 0, 0, 0, 0);         tick(32'h604);
        drive(0, 1, 32'h800, 0, 0);   tick(32'h604);
        drive(0, 0, 0, 1, 0);         tick(32'h4);
        n_vec++;
        if (Saved_PC !== 32'h604) begin
            n_err++; $display("FAIL wait_exc_saved: got %h want 604", Saved_PC);
        end
        drive(0, 0, 0, 0, 1);         tick(32'h4);
        drive(0, 0, 0, 0, 1);         tick(32'h8);
    endtask

    task automatic test_wrap;
        drive(0, 1, 32'hFFFF_FFF8, 0, 1); tick(32'hFFFF_FFF8);
        drive(0, 0, 0, 0, 1);
        #1;
        n_vec++;
        if (PC_Plus_8 !== 32'h0 || PC_Plus_4 !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_plus: got %h/%h want 0/fffffffc", PC_Plus_8, PC_Plus_4);
        end
        tick(32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 1);         tick(32'h0);
        drive(1, 0, 0, 0, 1);
        #1;
        n_vec++;
        if (Fetch_Valid !== 1'b0) begin
            n_err++; $display("FAIL stall_fv: got %b want 0", Fetch_Valid);
        end
        tick(32'h0);
        drive(1, 0, 0, 0, 1);         tick(32'h0);
        drive(0, 0, 0, 0, 1);         tick(32'h4);
        drive(0, 0, 0, 0, 0);         tick(32'h4);
        drive(0, 1, 32'h700, 0, 0);   tick(32'h4);
        @(negedge CLK);
        Reset_n = 1'b0; PCSrc = 0; IMem_Ready = 1;
        #1;
        n_vec++;
        if (current_PC !== 32'h0 || Saved_PC !== 32'h0) begin
            n_err++; $display("FAIL async_reset: pc=%h saved=%h want 0/0", current_PC, Saved_PC);
        end
        @(posedge CLK);
        @(negedge CLK);
        Reset_n = 1'b1;
        tick(32'h0);
        drive(0, 0, 0, 0, 1);         tick(32'h4);
        drive(0, 0, 0, 0, 1);         tick(32'h8);
    endtask

    initial begin
        test_reset;
        test_redirect;
        test_wait;
        test_misalign;
        test_exception;
        test_back_to_back;
        test_wrap;
        @(negedge CLK);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pc_unit_ext.md
Name: pc_unit_ext

Overview:
Parametrised fetch-stage program counter, successor to the single-cycle PC. Adds stall, instruction-memory ready handshake, buffered branch redirect, exception vectoring and misaligned-target trapping. Sits between the Result/PCSrc writeback path and the instruction memory address port. Supplies PC+4 and PC+8 (ARM PC-read value) to the datapath.

Parameters:
WIDTH, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0004, PC value loaded on exception or misaligned trap
STEP, 4, sequential increment in bytes
ALIGN_CHECK, 1, 1 = trap when a redirect target has Result[1:0] != 0; 0 = no check

Ports:
CLK  in  1  system clock, rising edge
Reset_n  in  1  reset; asynchronous, active-low
Stall  in  1  hold the PC this cycle (hazard unit)
PCSrc  in  1  redirect request; target on Result
Result  in  WIDTH  redirect target address
Exception  in  1  synchronous exception request
IMem_Ready  in  1  instruction memory has accepted current_PC this cycle
current_PC  out  WIDTH  fetch address (registered)
PC_Plus_4  out  WIDTH  current_PC + STEP, combinational, mod 2^WIDTH
PC_Plus_8  out  WIDTH  current_PC + 2*STEP, combinational, mod 2^WIDTH
Fetch_Valid  out  1  instruction fetched at current_PC is valid this cycle
Saved_PC  out  WIDTH  PC of the instruction interrupted by the last trap
Misaligned  out  1  high during TRAP when the trap cause was a misaligned target

Behaviour:
- Reset (Reset_n low, asynchronous): current_PC=RESET_VECTOR, state=BOOT, Saved_PC=0, Misaligned=0, pend_valid=0, pend_addr=0. Fetch_Valid=0.
- States: BOOT, RUN, WAIT, TRAP.
- BOOT: single cycle; PC held; next state RUN. Inputs ignored.
- RUN, per rising edge, first matching rule wins:
  1. Exception: Saved_PC<=current_PC; PC<=EXC_VECTOR; go to TRAP.
  2. PCSrc with ALIGN_CHECK=1 and Result[1:0]!=0: Saved_PC<=current_PC; Misaligned<=1; PC<=EXC_VECTOR; go to TRAP.
  3. PCSrc and IMem_Ready: PC<=Result; stay in RUN (Stall does not block a redirect).
  4. PCSrc and !IMem_Ready: pend_addr<=Result; pend_valid<=1; PC held; go to WAIT.
  5. !IMem_Ready: PC held; go to WAIT.
  6. Stall: PC held; stay in RUN.
  7. Otherwise: PC<=PC+STEP, wrapping at 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000).
- WAIT: current_PC stays stable until IMem_Ready=1.
  - PCSrc in WAIT overwrites pend_addr (latest target wins). The misalignment check applies here too and takes the TRAP path.
  - Exception in WAIT: TRAP path; pend_valid cleared.
  - IMem_Ready=1: PC<=pend_addr if pend_valid, else PC+STEP; pend_valid<=0; go to RUN. Stall in this cycle blocks only the sequential increment, never the pending redirect.
- TRAP: single cycle; PC held at EXC_VECTOR; Exception and PCSrc ignored (no nesting); Misaligned<=0 on exit; next state RUN.
- Fetch_Valid = (state==RUN) & IMem_Ready & !Stall & !PCSrc & !Exception. It is combinational and low in BOOT, WAIT and TRAP.
- Saved_PC changes only on trap entry.
- Reset mid-WAIT or mid-TRAP: all state is discarded immediately and the pending redirect is lost.

Decomposition:
- Shared package/header (pc_defs): state encodings BOOT=2'd0, RUN=2'd1, WAIT=2'd2, TRAP=2'd3; default RESET_VECTOR, EXC_VECTOR and STEP constants.
- One natural sub-module: pc_redirect_buf. It holds pend_valid/pend_addr, with capture, overwrite and clear on consume/trap/reset.
- Adders and next-PC mux stay in the top level.

Test Plan:
- Reset_n low for 10ns, then high, IMem_Ready=1 -> current_PC=0 through BOOT, then 0,4,8,C on successive edges; Fetch_Valid=0 in BOOT and 1 afterwards.
- At PC=0x10, PCSrc=1, Result=0x100 for one cycle -> next PC=0x100, then 0x104; PC_Plus_8=0x108 while PC=0x100.
- At PC=0x20, IMem_Ready=0 for 3 cycles; PCSrc pulses Result=0x200 then Result=0x300 during the wait -> PC held at 0x20, then 0x300 on the first ready edge; 0x200 is never fetched.
- At PC=0x40, PCSrc=1, Result=0x102 -> PC=0x4 and Misaligned=1 for one cycle, Saved_PC=0x40, then 0x8.
- At PC=0x80, Exception and PCSrc (Result=0x500) asserted together -> PC=0x4, Saved_PC=0x80; the redirect is dropped.
- Start with PC=0xFFFF_FFF8 (via redirect), free-run -> 0xFFFF_FFFC, then 0x0; Stall high for 2 cycles holds the PC; Reset_n pulsed low during WAIT returns PC to 0 immediately.
